// File: rtl/hm_tx_mrd_if.sv
// TRN transmit bundle between the MRd requester and the PCIe core.
//   master : requester side (drives beat data/framing, observes core status)
//   slave  : core side (drives link/buffer/ready status, consumes beats)
// Signals:
//   trn_lnk_up_n    link up, active-low
//   trn_tbuf_av     transmit buffer availability, bit 1 = non-posted credit
//   trn_tdst_rdy_n  core accepts beat when 0
//   trn_td          64-bit beat, first DW in [63:32]
//   trn_trem_n      0: all 8 bytes valid, 1: only [63:32] valid
//   trn_tsof_n / trn_teof_n / trn_tsrc_rdy_n  framing, active-low
//   trn_tsrc_dsc_n / trn_terrfwd_n            discontinue / error-forward, active-low
interface hm_tx_mrd_if;
    logic        trn_lnk_up_n;
    logic [5:0]  trn_tbuf_av;
    logic        trn_tdst_rdy_n;
    logic [63:0] trn_td;
    logic        trn_trem_n;
    logic        trn_tsof_n;
    logic        trn_teof_n;
    logic        trn_tsrc_rdy_n;
    logic        trn_tsrc_dsc_n;
    logic        trn_terrfwd_n;

    modport master (
        input  trn_lnk_up_n, trn_tbuf_av, trn_tdst_rdy_n,
        output trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n,
               trn_tsrc_dsc_n, trn_terrfwd_n
    );

    modport slave (
        output trn_lnk_up_n, trn_tbuf_av, trn_tdst_rdy_n,
        input  trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n,
               trn_tsrc_dsc_n, trn_terrfwd_n
    );
endinterface

// File: rtl/hm_tx_mrd.sv
// Memory Read requester on the Virtex-6 PCIe TRN transmit interface.
// On tx_start the host region (hm_addr, hm_len_dw) is split into MRd TLPs of
// at most MAX_RD_DW DW that never cross a 4 KB page. 3DW headers are used
// while the address fits in 32 bits, 4DW otherwise. Each TLP is two beats.
// Ports:
//   trn_clk, sys_rst        clock, asynchronous active-high reset
//   trn                     TRN transmit bundle (master side)
//   tx_start                pulse: latch hm_addr / hm_len_dw (IDLE only)
//   hm_addr, hm_len_dw      byte address (DW aligned) and length in DW
//   abort                   stop after the TLP in flight
//   tx_end                  pulse when the request sequence is finished
//   cfg_bus/device/function_number  requester ID
//   stat_trn_cpt_tx         count of accepted TLPs (wraps)
//   stat_state              current FSM state
module hm_tx_mrd #(
    parameter int MAX_RD_DW = 128
) (
    input  logic              trn_clk,
    input  logic              sys_rst,
    hm_tx_mrd_if.master       trn,
    input  logic              tx_start,
    input  logic [63:0]       hm_addr,
    input  logic [10:0]       hm_len_dw,
    input  logic              abort,
    output logic              tx_end,
    input  logic [7:0]        cfg_bus_number,
    input  logic [4:0]        cfg_device_number,
    input  logic [2:0]        cfg_function_number,
    output logic [31:0]       stat_trn_cpt_tx,
    output logic [1:0]        stat_state
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        HDR0 = 2'b10,
        HDR1 = 2'b11
    } state_t;

    localparam logic [10:0] MAX_DW = 11'(MAX_RD_DW);

    state_t      state_reg;
    logic [61:0] cur_addr_reg;     // DW address
    logic [10:0] rem_reg;
    logic [10:0] chunk_reg;
    logic [7:0]  tag_reg;
    logic        abort_reg;
    logic        tx_end_reg;
    logic [31:0] stat_reg;
    logic [63:0] td_reg;
    logic        trem_n_reg;
    logic        tsof_n_reg;
    logic        teof_n_reg;
    logic        tsrc_rdy_n_reg;

    logic [10:0] page_left;
    logic [10:0] chunk_next;
    logic        is_4dw;
    logic [15:0] req_id;
    logic [31:0] dw0;
    logic [31:0] dw1;
    logic [63:0] hdr1_td;
    logic        unused_bits;

    // DW left before the next 4 KB boundary: 1..1024
    assign page_left = 11'd1024 - {1'b0, cur_addr_reg[9:0]};

    always_comb begin
        chunk_next = rem_reg;
        if (MAX_DW < chunk_next) begin
            chunk_next = MAX_DW;
        end
        if (page_left < chunk_next) begin
            chunk_next = page_left;
        end
    end

    assign is_4dw = |cur_addr_reg[61:30];
    assign req_id = {cfg_bus_number, cfg_device_number, cfg_function_number};

    // fmt in [30:29], type MRd = 0, TC/TD/EP/attr = 0; a 1024 DW chunk encodes as length 0
    assign dw0 = {1'b0, 1'b0, is_4dw, 5'b00000, 14'h0, chunk_next[9:0]};
    assign dw1 = {req_id, tag_reg, (chunk_next == 11'd1) ? 4'h0 : 4'hF, 4'hF};

    // Second beat: address only (3DW leaves the low half unused)
    assign hdr1_td = is_4dw ? {cur_addr_reg[61:30], cur_addr_reg[29:0], 2'b00}
                            : {cur_addr_reg[29:0], 2'b00, 32'h0};

    assign unused_bits = ^{trn.trn_tbuf_av[5:2], trn.trn_tbuf_av[0], hm_addr[1:0]};

    always_ff @(posedge trn_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_reg      <= IDLE;
            cur_addr_reg   <= '0;
            rem_reg        <= '0;
            chunk_reg      <= '0;
            tag_reg        <= '0;
            abort_reg      <= 1'b0;
            tx_end_reg     <= 1'b0;
            stat_reg       <= '0;
            td_reg         <= '0;
            trem_n_reg     <= 1'b1;
            tsof_n_reg     <= 1'b1;
            teof_n_reg     <= 1'b1;
            tsrc_rdy_n_reg <= 1'b1;
        end else begin
            tx_end_reg <= 1'b0;

            // Abort is remembered until the sequence returns to IDLE
            if (state_reg == IDLE) begin
                abort_reg <= 1'b0;
            end else if (abort) begin
                abort_reg <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (tx_start) begin
                        if (trn.trn_lnk_up_n || (hm_len_dw == 11'd0)) begin
                            tx_end_reg <= 1'b1;
                        end else begin
                            cur_addr_reg <= hm_addr[63:2];
                            rem_reg      <= hm_len_dw;
                            state_reg    <= CALC;
                        end
                    end
                end

                CALC: begin
                    if (trn.trn_lnk_up_n || (rem_reg == 11'd0) || abort_reg || abort) begin
                        tx_end_reg <= 1'b1;
                        state_reg  <= IDLE;
                    end else if (trn.trn_tbuf_av[1]) begin
                        chunk_reg      <= chunk_next;
                        td_reg         <= {dw0, dw1};
                        trem_n_reg     <= 1'b0;
                        tsof_n_reg     <= 1'b0;
                        teof_n_reg     <= 1'b1;
                        tsrc_rdy_n_reg <= 1'b0;
                        state_reg      <= HDR0;
                    end
                end

                HDR0, HDR1: begin
                    if (trn.trn_lnk_up_n) begin
                        // Link lost: drop the TLP and finish
                        td_reg         <= '0;
                        trem_n_reg     <= 1'b1;
                        tsof_n_reg     <= 1'b1;
                        teof_n_reg     <= 1'b1;
                        tsrc_rdy_n_reg <= 1'b1;
                        tx_end_reg     <= 1'b1;
                        state_reg      <= IDLE;
                    end else if (!trn.trn_tdst_rdy_n) begin
                        if (state_reg == HDR0) begin
                            td_reg     <= hdr1_td;
                            trem_n_reg <= !is_4dw;
                            tsof_n_reg <= 1'b1;
                            teof_n_reg <= 1'b0;
                            state_reg  <= HDR1;
                        end else begin
                            cur_addr_reg   <= cur_addr_reg + {51'h0, chunk_reg};
                            rem_reg        <= rem_reg - chunk_reg;
                            tag_reg        <= tag_reg + 8'd1;
                            stat_reg       <= stat_reg + 32'd1;
                            td_reg         <= '0;
                            trem_n_reg     <= 1'b1;
                            tsof_n_reg     <= 1'b1;
                            teof_n_reg     <= 1'b1;
                            tsrc_rdy_n_reg <= 1'b1;
                            state_reg      <= CALC;
                        end
                    end
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

    assign trn.trn_td         = td_reg;
    assign trn.trn_trem_n     = trem_n_reg;
    assign trn.trn_tsof_n     = tsof_n_reg;
    assign trn.trn_teof_n     = teof_n_reg;
    assign trn.trn_tsrc_rdy_n = tsrc_rdy_n_reg;
    assign trn.trn_tsrc_dsc_n = 1'b1;
    assign trn.trn_terrfwd_n  = 1'b1;

    assign tx_end          = tx_end_reg;
    assign stat_trn_cpt_tx = stat_reg;
    assign stat_state      = state_reg;

endmodule

// File: tb/tb_hm_tx_mrd.sv
// Bench for hm_tx_mrd (MAX_RD_DW = 128, requester ID 0x1219).
// A table of transfers with hand-computed TLP beats is replayed first, then
// hand-written sequences cover stalls, abort, link loss, buffer wait and reset.
module tb_hm_tx_mrd;

    logic        trn_clk = 1'b0;
    logic        sys_rst;
    logic        tx_start;
    logic [63:0] hm_addr;
    logic [10:0] hm_len_dw;
    logic        abort;
    logic        tx_end;
    logic [7:0]  cfg_bus_number;
    logic [4:0]  cfg_device_number;
    logic [2:0]  cfg_function_number;
    logic [31:0] stat_trn_cpt_tx;
    logic [1:0]  stat_state;

    hm_tx_mrd_if trn();

    always #5 trn_clk = ~trn_clk;

    hm_tx_mrd #(.MAX_RD_DW(128)) dut (
        .trn_clk             (trn_clk),
        .sys_rst             (sys_rst),
        .trn                 (trn),
        .tx_start            (tx_start),
        .hm_addr             (hm_addr),
        .hm_len_dw           (hm_len_dw),
        .abort               (abort),
        .tx_end              (tx_end),
        .cfg_bus_number      (cfg_bus_number),
        .cfg_device_number   (cfg_device_number),
        .cfg_function_number (cfg_function_number),
        .stat_trn_cpt_tx     (stat_trn_cpt_tx),
        .stat_state          (stat_state)
    );

    typedef struct {
        logic [63:0] addr;
        logic [10:0] len;
        int          first;
        int          n;
    } xfer_t;

    typedef struct {
        logic [63:0] b0;
        logic [63:0] b1;
        logic        trem1;
    } tlp_t;

    xfer_t xv[7];
    tlp_t  tv[11];

    logic [63:0] cap_td[16];
    logic [2:0]  cap_fl[16];   // {tsof_n, teof_n, trem_n}

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_td"}, trn.trn_td, 64'h0);
        check({name, "_flags"}, {trn.trn_tsrc_rdy_n, trn.trn_tsof_n, trn.trn_teof_n,
                                 trn.trn_trem_n, trn.trn_tsrc_dsc_n, trn.trn_terrfwd_n}, 6'h3F);
        check({name, "_tx_end"}, tx_end, 1'b0);
    endtask

    task automatic pulse_start(input logic [63:0] a, input logic [10:0] l);
        hm_addr   = a;
        hm_len_dw = l;
        tx_start  = 1'b1;
        @(negedge trn_clk);
        tx_start  = 1'b0;
    endtask

    task automatic wait_state(input logic [1:0] st, input string name);
        int c = 0;
        while (stat_state != st && c < 50) begin
            @(negedge trn_clk);
            c++;
        end
        check(name, stat_state, st);
    endtask

    // Waits for tx_end (bounded), counting start-of-frame beats offered meanwhile
    task automatic wait_end(input string name, output int nsof);
        int c = 0;
        nsof = 0;
        while (!tx_end && c < 200) begin
            if (!trn.trn_tsof_n && !trn.trn_tsrc_rdy_n) nsof++;
            @(negedge trn_clk);
            c++;
        end
        check(name, tx_end, 1'b1);
        @(negedge trn_clk);
    endtask

    // Runs one transfer with the core always ready, capturing every accepted beat
    task automatic run_xfer(input logic [63:0] a, input logic [10:0] l,
                            output int nb, output int nend, output int end_cyc);
        pulse_start(a, l);
        nb      = 0;
        nend    = 0;
        end_cyc = -1;
        for (int c = 0; c < 3000 && end_cyc < 0; c++) begin
            if (!trn.trn_tsrc_rdy_n && !trn.trn_tdst_rdy_n) begin
                if (nb < 16) begin
                    cap_td[nb] = trn.trn_td;
                    cap_fl[nb] = {trn.trn_tsof_n, trn.trn_teof_n, trn.trn_trem_n};
                end
                nb++;
            end
            if (tx_end) begin
                nend++;
                end_cyc = c;
            end
            @(negedge trn_clk);
        end
        check("tx_end_seen", (end_cyc >= 0), 1'b1);
        for (int c = 0; c < 6; c++) begin
            if (tx_end) nend++;
            if (!trn.trn_tsrc_rdy_n) nb++;
            @(negedge trn_clk);
        end
    endtask

    initial begin
        int nb, nend, ec, nsof;
        logic [63:0] td_hold;

        xv[0] = '{64'h0000_0000_0000_1000, 11'd256, 0, 2};
        xv[1] = '{64'h0000_0000_0000_0FF0, 11'd8,   2, 2};
        xv[2] = '{64'h0000_0001_0000_0000, 11'd1,   4, 1};
        xv[3] = '{64'h0000_0000_0000_2F00, 11'd300, 5, 3};
        xv[4] = '{64'h0000_0000_FFFF_FF00, 11'd128, 8, 2};
        xv[5] = '{64'h0000_0000_0000_0010, 11'd2,  10, 1};
        xv[6] = '{64'h0000_0000_0000_5000, 11'd0,  11, 0};

        tv[0]  = '{64'h00000080_121900FF, 64'h00001000_00000000, 1'b1};
        tv[1]  = '{64'h00000080_121901FF, 64'h00001200_00000000, 1'b1};
        tv[2]  = '{64'h00000004_121902FF, 64'h00000FF0_00000000, 1'b1};
        tv[3]  = '{64'h00000004_121903FF, 64'h00001000_00000000, 1'b1};
        tv[4]  = '{64'h20000001_1219040F, 64'h00000001_00000000, 1'b0};
        tv[5]  = '{64'h00000040_121905FF, 64'h00002F00_00000000, 1'b1};
        tv[6]  = '{64'h00000080_121906FF, 64'h00003000_00000000, 1'b1};
        tv[7]  = '{64'h0000006C_121907FF, 64'h00003200_00000000, 1'b1};
        tv[8]  = '{64'h00000040_121908FF, 64'hFFFFFF00_00000000, 1'b1};
        tv[9]  = '{64'h20000040_121909FF, 64'h00000001_00000000, 1'b0};
        tv[10] = '{64'h00000002_12190AFF, 64'h00000010_00000000, 1'b1};

        sys_rst             = 1'b1;
        tx_start            = 1'b0;
        hm_addr             = '0;
        hm_len_dw           = '0;
        abort               = 1'b0;
        cfg_bus_number      = 8'h12;
        cfg_device_number   = 5'h03;
        cfg_function_number = 3'h1;
        trn.trn_lnk_up_n    = 1'b0;
        trn.trn_tbuf_av     = 6'h3F;
        trn.trn_tdst_rdy_n  = 1'b0;

        repeat (3) @(negedge trn_clk);
        check_idle_outputs("reset");
        check("reset_stat", stat_trn_cpt_tx, 32'd0);
        check("reset_state", stat_state, 2'b00);
        sys_rst = 1'b0;
        @(negedge trn_clk);

        // Table-driven transfers, core always ready
        for (int i = 0; i < 7; i++) begin
            run_xfer(xv[i].addr, xv[i].len, nb, nend, ec);
            $display("xfer %0d: addr=0x%0h len=%0d beats=%0d tx_end=%0d", i, xv[i].addr, xv[i].len, nb, nend);
            check($sformatf("x%0d_beats", i), nb, 2 * xv[i].n);
            check($sformatf("x%0d_tx_end_count", i), nend, 1);
            check($sformatf("x%0d_state", i), stat_state, 2'b00);
            if (xv[i].len == 11'd0) check($sformatf("x%0d_end_latency", i), ec, 0);
            for (int k = 0; k < xv[i].n && 2 * k + 1 < 16; k++) begin
                check($sformatf("x%0d_t%0d_beat0", i, k), cap_td[2*k],   tv[xv[i].first+k].b0);
                check($sformatf("x%0d_t%0d_beat1", i, k), cap_td[2*k+1], tv[xv[i].first+k].b1);
                check($sformatf("x%0d_t%0d_fl0", i, k),   cap_fl[2*k],   3'b010);
                check($sformatf("x%0d_t%0d_fl1", i, k),   cap_fl[2*k+1], {2'b10, tv[xv[i].first+k].trem1});
            end
        end
        check("stat_after_table", stat_trn_cpt_tx, 32'd11);

        // Stall in HDR0 and HDR1: beats held, TLP counted once
        trn.trn_tdst_rdy_n = 1'b1;
        pulse_start(64'h8000, 11'd4);
        wait_state(2'b10, "stall_reach_hdr0");
        for (int c = 0; c < 5; c++) begin
            @(negedge trn_clk);
            check("stall_hdr0_td", trn.trn_td, 64'h00000004_12190BFF);
            check("stall_hdr0_fl", {trn.trn_tsof_n, trn.trn_teof_n, trn.trn_trem_n, trn.trn_tsrc_rdy_n}, 4'b0100);
        end
        trn.trn_tdst_rdy_n = 1'b0;
        @(negedge trn_clk);
        trn.trn_tdst_rdy_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check("stall_hdr1_state", stat_state, 2'b11);
            check("stall_hdr1_td", trn.trn_td, 64'h00008000_00000000);
            check("stall_hdr1_fl", {trn.trn_tsof_n, trn.trn_teof_n, trn.trn_trem_n, trn.trn_tsrc_rdy_n}, 4'b1010);
            check("stall_hdr1_stat", stat_trn_cpt_tx, 32'd11);
            @(negedge trn_clk);
        end
        trn.trn_tdst_rdy_n = 1'b0;
        @(negedge trn_clk);
        check("stall_done_stat", stat_trn_cpt_tx, 32'd12);
        check("stall_done_src", trn.trn_tsrc_rdy_n, 1'b1);
        wait_end("stall_tx_end", nsof);
        $display("stall: stat=%0d", stat_trn_cpt_tx);

        // Abort during HDR1 of the first of four TLPs
        pulse_start(64'h1_0000, 11'd512);
        wait_state(2'b11, "abort_reach_hdr1");
        abort = 1'b1;
        @(negedge trn_clk);
        abort = 1'b0;
        wait_end("abort_tx_end", nsof);
        $display("abort: stat=%0d extra_sof=%0d", stat_trn_cpt_tx, nsof);
        check("abort_no_more_tlp", nsof, 0);
        check("abort_stat", stat_trn_cpt_tx, 32'd13);
        check("abort_state", stat_state, 2'b00);

        // tx_start while the link is down: immediate tx_end, no TLP
        trn.trn_lnk_up_n = 1'b1;
        pulse_start(64'h7000, 11'd4);
        $display("link down start: tx_end=%0d state=%0d", tx_end, stat_state);
        check("lnkdn_tx_end", tx_end, 1'b1);
        check("lnkdn_state", stat_state, 2'b00);
        @(negedge trn_clk);
        check("lnkdn_tx_end_pulse", tx_end, 1'b0);
        trn.trn_lnk_up_n = 1'b0;

        // Link drop while HDR0 is stalled
        trn.trn_tdst_rdy_n = 1'b1;
        pulse_start(64'h9000, 11'd4);
        wait_state(2'b10, "drop_reach_hdr0");
        trn.trn_lnk_up_n = 1'b1;
        @(negedge trn_clk);
        $display("link drop: src_rdy_n=%0d tx_end=%0d state=%0d", trn.trn_tsrc_rdy_n, tx_end, stat_state);
        check("drop_src_rdy", trn.trn_tsrc_rdy_n, 1'b1);
        check("drop_tx_end", tx_end, 1'b1);
        check("drop_state", stat_state, 2'b00);
        check("drop_stat", stat_trn_cpt_tx, 32'd13);
        trn.trn_lnk_up_n   = 1'b0;
        trn.trn_tdst_rdy_n = 1'b0;
        @(negedge trn_clk);

        // No non-posted buffer: stay in CALC without offering a beat
        trn.trn_tbuf_av = 6'h3D;
        pulse_start(64'hA000, 11'd4);
        for (int c = 0; c < 4; c++) begin
            check("tbuf_wait_state", stat_state, 2'b01);
            check("tbuf_wait_src", trn.trn_tsrc_rdy_n, 1'b1);
            @(negedge trn_clk);
        end
        trn.trn_tbuf_av = 6'h3F;
        wait_end("tbuf_tx_end", nsof);
        $display("tbuf wait: stat=%0d sof=%0d", stat_trn_cpt_tx, nsof);
        check("tbuf_one_tlp", nsof, 1);
        check("tbuf_stat", stat_trn_cpt_tx, 32'd14);

        // Asynchronous reset in HDR0, then restart with tag 0
        trn.trn_tdst_rdy_n = 1'b1;
        pulse_start(64'h4000, 11'd4);
        wait_state(2'b10, "rst_reach_hdr0");
        #2;
        sys_rst = 1'b1;
        #1;
        $display("async reset: state=%0d src_rdy_n=%0d stat=%0d", stat_state, trn.trn_tsrc_rdy_n, stat_trn_cpt_tx);
        check_idle_outputs("async_rst");
        check("async_rst_state", stat_state, 2'b00);
        check("async_rst_stat", stat_trn_cpt_tx, 32'd0);
        @(negedge trn_clk);
        sys_rst            = 1'b0;
        trn.trn_tdst_rdy_n = 1'b0;
        @(negedge trn_clk);
        run_xfer(64'h4000, 11'd4, nb, nend, ec);
        $display("restart: beats=%0d tx_end=%0d", nb, nend);
        check("restart_beats", nb, 2);
        check("restart_beat0", cap_td[0], 64'h00000004_121900FF);
        check("restart_beat1", cap_td[1], 64'h00004000_00000000);
        check("restart_stat", stat_trn_cpt_tx, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
